// File: rtl/onehot_index_decoder.sv
// Binary index to one-hot decoder behind a 2-entry valid/ready buffer, with a transfer counter.
// Define ONEHOT_DEC_ACC_EN to include the sticky OR-accumulator on acc_mask; otherwise acc_mask is 0.
module onehot_index_decoder #(
    parameter  int IDX_W = 3,
    localparam int N     = 2 ** IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_onehot,
    output logic [7:0]       xfer_cnt,
    input  logic             acc_clr,
    output logic [N-1:0]     acc_mask
);

    logic [1:0]   r_occ;
    logic [N-1:0] r_head;
    logic [N-1:0] r_tail;
    logic         r_in_ready;
    logic [7:0]   r_xfer_cnt;

    logic         w_push;
    logic         w_pop;
    logic [N-1:0] w_word;
    logic [1:0]   w_occ_nxt;
    logic [N-1:0] w_head_nxt;
    logic [N-1:0] w_tail_nxt;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = out_valid & out_ready;

    always_comb begin
        w_word = '0;
        if (in_en) begin
            w_word = N'(1) << in_idx;
        end
    end

    // The head register drives out_onehot directly; it is zeroed whenever the buffer drains.
    always_comb begin
        w_occ_nxt  = r_occ;
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        case (r_occ)
            2'd0: begin
                if (w_push) begin
                    w_head_nxt = w_word;
                    w_occ_nxt  = 2'd1;
                end
            end
            2'd1: begin
                case ({w_push, w_pop})
                    2'b11: w_head_nxt = w_word;
                    2'b10: begin
                        w_tail_nxt = w_word;
                        w_occ_nxt  = 2'd2;
                    end
                    2'b01: begin
                        w_head_nxt = '0;
                        w_occ_nxt  = 2'd0;
                    end
                    default: ;
                endcase
            end
            2'd2: begin
                if (w_pop) begin
                    w_head_nxt = r_tail;
                    w_occ_nxt  = 2'd1;
                end
            end
            default: begin
                w_head_nxt = '0;
                w_occ_nxt  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= 2'd0;
            r_head     <= '0;
            r_tail     <= '0;
            r_in_ready <= 1'b0;
            r_xfer_cnt <= 8'd0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_in_ready <= (w_occ_nxt != 2'd2);
            if (w_pop) begin
                r_xfer_cnt <= r_xfer_cnt + 8'd1;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = (r_occ != 2'd0);
    assign out_onehot = r_head;
    assign xfer_cnt   = r_xfer_cnt;

`ifdef ONEHOT_DEC_ACC_EN
    logic [N-1:0] r_acc;

    // A clear in the same cycle as a handshake keeps only the word being delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (acc_clr) begin
            r_acc <= w_pop ? r_head : '0;
        end else if (w_pop) begin
            r_acc <= r_acc | r_head;
        end
    end

    assign acc_mask = r_acc;
`else
    logic w_unused_acc_clr;
    assign w_unused_acc_clr = acc_clr;
    assign acc_mask         = '0;
`endif

endmodule

// File: tb/tb_onehot_index_decoder.sv
// Directed self-checking bench for onehot_index_decoder: table-driven decode vectors plus
// hand-written stall, accumulator-clear, counter-wrap and reset-while-full sequences.
module tb_onehot_index_decoder;

    localparam int IDX_W = 3;
    localparam int N     = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic             in_en;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_onehot;
    logic [7:0]       xfer_cnt;
    logic             acc_clr;
    logic [N-1:0]     acc_mask;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   exp_cnt;
    logic [N-1:0] exp_acc;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic             en;
        logic [N-1:0]     onehot;
    } vec_t;

    vec_t vecs[9];

    onehot_index_decoder #(.IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .xfer_cnt   (xfer_cnt),
        .acc_clr    (acc_clr),
        .acc_mask   (acc_mask)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] acc_model(input logic [N-1:0] acc, input logic [N-1:0] w,
                                               input logic clr);
`ifdef ONEHOT_DEC_ACC_EN
        return clr ? w : (acc | w);
`else
        return '0;
`endif
    endfunction

    // Push one word into an empty buffer, check it on the output, then pop it.
    task automatic send(input logic [IDX_W-1:0] idx, input logic en, input logic [N-1:0] exp,
                        input logic clr);
        chk("in_ready_before_push", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_idx    = idx;
        in_en     = en;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("out_valid_after_push", 32'(out_valid), 32'd1);
        chk("out_onehot", 32'(out_onehot), 32'(exp));
        acc_clr = clr;
        step();
        acc_clr = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        exp_acc = acc_model(exp_acc, exp, clr);
        chk("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
        chk("acc_mask", 32'(acc_mask), 32'(exp_acc));
        chk("out_valid_after_pop", 32'(out_valid), 32'd0);
        chk("out_onehot_empty", 32'(out_onehot), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        exp_cnt  = 8'd0;
        exp_acc  = '0;
    endtask

    initial begin
        vecs[0] = '{idx: 3'd5, en: 1'b1, onehot: 8'h20};
        vecs[1] = '{idx: 3'd0, en: 1'b1, onehot: 8'h01};
        vecs[2] = '{idx: 3'd7, en: 1'b1, onehot: 8'h80};
        vecs[3] = '{idx: 3'd7, en: 1'b0, onehot: 8'h00};
        vecs[4] = '{idx: 3'd3, en: 1'b1, onehot: 8'h08};
        vecs[5] = '{idx: 3'd1, en: 1'b1, onehot: 8'h02};
        vecs[6] = '{idx: 3'd0, en: 1'b0, onehot: 8'h00};
        vecs[7] = '{idx: 3'd6, en: 1'b1, onehot: 8'h40};
        vecs[8] = '{idx: 3'd4, en: 1'b1, onehot: 8'h10};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_idx    = '0;
        in_en     = 1'b0;
        out_ready = 1'b0;
        acc_clr   = 1'b0;

        // Reset state
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_onehot", 32'(out_onehot), 32'd0);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        chk("rst_acc_mask", 32'(acc_mask), 32'd0);
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Decode table, first entry is idx 5
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].idx, vecs[i].en, vecs[i].onehot, 1'b0);
        end

        // Stall: fill both entries, third word is held off
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_en     = 1'b1;
        in_idx    = 3'd1;
        step();
        chk("stall_in_ready_occ1", 32'(in_ready), 32'd1);
        in_idx = 3'd2;
        step();
        chk("stall_in_ready_full", 32'(in_ready), 32'd0);
        in_idx = 3'd3;
        step();
        chk("stall_still_full", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_head_stable", 32'(out_onehot), 32'h02);
        out_ready = 1'b1;
        step();
        exp_cnt = exp_cnt + 8'd1;
        exp_acc = acc_model(exp_acc, 8'h02, 1'b0);
        chk("drain_word2", 32'(out_onehot), 32'h04);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        exp_cnt  = exp_cnt + 8'd1;
        exp_acc  = acc_model(exp_acc, 8'h04, 1'b0);
        chk("drain_word3", 32'(out_onehot), 32'h08);
        chk("drain_word3_valid", 32'(out_valid), 32'd1);
        step();
        exp_cnt = exp_cnt + 8'd1;
        exp_acc = acc_model(exp_acc, 8'h08, 1'b0);
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
        chk("drain_acc_mask", 32'(acc_mask), 32'(exp_acc));

        // Accumulator: clear alone, gather 0/7/3, then clear with idx 4 handshake
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        exp_acc = '0;
        chk("clr_alone_acc", 32'(acc_mask), 32'd0);
        chk("clr_alone_xfer", 32'(xfer_cnt), 32'(exp_cnt));
        send(3'd0, 1'b1, 8'h01, 1'b0);
        send(3'd7, 1'b1, 8'h80, 1'b0);
        send(3'd3, 1'b1, 8'h08, 1'b0);
`ifdef ONEHOT_DEC_ACC_EN
        chk("acc_after_0_7_3", 32'(acc_mask), 32'h89);
`else
        chk("acc_after_0_7_3", 32'(acc_mask), 32'h00);
`endif
        send(3'd4, 1'b1, 8'h10, 1'b1);

        // 256 handshakes from reset at full throughput, then fill and reset while full
        do_reset();
        step();
        in_en = 1'b1;
        for (int m = 1; m <= 258; m++) begin
            in_valid  = 1'b1;
            in_idx    = 3'(m % 8);
            out_ready = (m <= 257);
            step();
            if (m <= 257) begin
                chk("thru_onehot", 32'(out_onehot), 32'(8'd1 << (m % 8)));
            end
            if (m == 256) begin
                chk("xfer_cnt_255", 32'(xfer_cnt), 32'd255);
            end
            if (m == 257) begin
                chk("xfer_cnt_wrap", 32'(xfer_cnt), 32'd0);
            end
        end
        in_valid = 1'b0;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_head", 32'(out_onehot), 32'h02);
`ifdef ONEHOT_DEC_ACC_EN
        chk("wrap_acc_mask", 32'(acc_mask), 32'hFF);
`else
        chk("wrap_acc_mask", 32'(acc_mask), 32'h00);
`endif
        out_ready = 1'b1;
        do_reset();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_onehot", 32'(out_onehot), 32'd0);
        chk("midrst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_acc_mask", 32'(acc_mask), 32'd0);
        step();
        chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
        chk("midrst_out_valid_after", 32'(out_valid), 32'd0);
        chk("midrst_xfer_cnt_after", 32'(xfer_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/onehot_index_decoder.md
Name: onehot_index_decoder

Overview:
- Inverse of the team's priority index encoder: turns a stream of binary indices back into one-hot bit vectors.
- Inputs arrive over a valid/ready handshake and pass through a 2-entry buffer, so a stalled consumer never drops data.
- Each delivered word is optionally OR-accumulated into a sticky mask, and delivered transfers are counted.
- Sits downstream of the encoder, e.g. to rebuild request/grant masks from encoded indices.

Parameters:
- IDX_W, 3, index width; output width N = 2**IDX_W (default 8).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset, sampled on rising edge of clk.
- in_valid  input  1  upstream has an index to deliver.
- in_ready  output  1  block can accept a word this cycle.
- in_idx  input  IDX_W  binary index.
- in_en  input  1  1: decode in_idx; 0: produce all-zero word (the "no bit set" case).
- out_valid  output  1  out_onehot holds a valid word.
- out_ready  input  1  downstream accepts the word.
- out_onehot  output  N  decoded one-hot word (or all-zero).
- xfer_cnt  output  8  count of output handshakes.
- acc_clr  input  1  clears accumulated mask.
- acc_mask  output  N  OR of every one-hot delivered since reset/clear.

Behaviour:
- Reset (rst=1 at edge): buffer emptied, count=0, in_ready=0 during the reset cycle and 1 from the first cycle after, out_valid=0, out_onehot=0, xfer_cnt=0, acc_mask=0.
  - Reset mid-operation discards all buffered words with no output handshake.
- Input handshake: in_valid & in_ready at an edge. Output handshake: out_valid & out_ready at an edge.
- Decode at push time: word = in_en ? (1 << in_idx) : 0. Stored word is exactly N bits; every in_idx value in 0..N-1 is legal.
- Buffer: 2-entry FIFO, state = occupancy 0/1/2.
  - in_ready = (occupancy < 2), registered; no combinational path from out_ready to in_ready.
  - out_valid = (occupancy > 0); out_onehot = head word, registered.
  - out_onehot is 0 whenever out_valid=0.
- Latency: word accepted at edge k is on out_onehot with out_valid=1 after edge k when the buffer was empty.
  - Full throughput: one word per cycle when out_ready is held 1.
- Simultaneous push and pop:
  - occupancy 1: occupancy stays 1 and the new word becomes head after the edge.
  - occupancy 2: push impossible (in_ready=0); pop only.
- Empty: out_ready ignored. Full: in_valid ignored, in_idx/in_en not sampled.
- Stall: while out_valid=1 and out_ready=0, out_onehot is stable.
- xfer_cnt: +1 per output handshake, wraps 255 -> 0; all-zero words count too.
- acc_mask:
  - On output handshake: acc_mask <= acc_mask | out_onehot.
  - acc_clr alone: acc_mask <= 0.
  - acc_clr with handshake in the same cycle: acc_mask <= out_onehot (clear, then OR).
  - acc_clr does not affect the buffer or xfer_cnt.

Optional Feature:
- Macro ONEHOT_DEC_ACC_EN.
- Defined: acc_mask register and acc_clr logic present as above.
- Undefined: no accumulator storage; acc_mask tied to 0 and acc_clr ignored. Buffer, handshake and xfer_cnt are identical in both builds.

Test Plan:
- Reset, then push in_idx=5, in_en=1 with out_ready=1 -> out_onehot=8'b0010_0000 with out_valid=1 one cycle after accept; xfer_cnt=1; acc_mask=8'h20.
- out_ready=0; push idx 1, 2, 3 back to back -> first two accepted, in_ready=0 after the second, idx 3 held by upstream. Release out_ready -> outputs 8'h02, 8'h04, 8'h08 in order, none lost or duplicated.
- Push in_en=0, in_idx=7 -> out_onehot=8'h00 with out_valid=1; xfer_cnt increments; acc_mask unchanged.
- Deliver idx 0, 7, 3, then pulse acc_clr in the same cycle as the handshake of idx 4 -> acc_mask goes 8'h89, then 8'h10.
- 256 output handshakes from reset -> xfer_cnt wraps to 0. Then assert rst with 2 words buffered -> out_valid=0 and xfer_cnt=0 the next cycle, in_ready=1 the cycle after.
- Build without ONEHOT_DEC_ACC_EN, rerun the first scenario -> identical out_onehot/xfer_cnt; acc_mask stays 0.
